// File: rtl/game_sequencer_pkg.sv
// Shared game geometry, constants and state encodings for the game sequencer.
package game_sequencer_pkg;

    localparam int unsigned BLOCK_COUNT = 72;
    localparam int unsigned CNT_W       = 7;
    localparam int unsigned Y_W         = 10;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned FRAME_W     = 6;

    // Ball is lost once its top edge passes the last row it can occupy on screen.
    localparam int unsigned SCREEN_H_PIXELS = 480;
    localparam int unsigned BALL_SIZE_PIXELS = 10;

    localparam logic [LIVES_W-1:0] DEFAULT_LIVES_INIT        = LIVES_W'(3);
    localparam logic [Y_W-1:0]     DEFAULT_LOST_Y_PIXEL      = Y_W'(SCREEN_H_PIXELS - BALL_SIZE_PIXELS);
    localparam logic [FRAME_W-1:0] DEFAULT_LOST_DELAY_FRAMES = FRAME_W'(30);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSED = 3'd2,
        ST_LOST   = 3'd3,
        ST_OVER   = 3'd4,
        ST_WON    = 3'd5
    } game_state_e;

endpackage

// File: rtl/game_sequencer_block_counter.sv
// Serial scanner counting set bits of the block-present vector, one bit per cycle.
module game_sequencer_block_counter
    import game_sequencer_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BLOCK_COUNT-1:0] vector,
    output logic                   done_c,
    output logic [CNT_W-1:0]       count_c
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_c;

    // Count and done are combinational so the caller can latch the final total on the last scan cycle.
    always_comb begin
        busy_d  = busy_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_c  = (idx_q == CNT_W'(BLOCK_COUNT - 1));
        count_c = cnt_q + CNT_W'(vector[idx_q]);
        done_c  = busy_q && last_c && !abort;

        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            idx_d  = '0;
            cnt_d  = '0;
        end else if (busy_q) begin
            cnt_d = count_c;
            idx_d = idx_q + CNT_W'(1);
            if (last_c) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: paces physics to the frame rate, tracks lives, pause, win/lose and blocks left.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter logic [LIVES_W-1:0] LIVES_INIT        = DEFAULT_LIVES_INIT,
    parameter logic [Y_W-1:0]     LOST_Y_PIXEL      = DEFAULT_LOST_Y_PIXEL,
    parameter logic [FRAME_W-1:0] LOST_DELAY_FRAMES = DEFAULT_LOST_DELAY_FRAMES
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FRAME_START,
    input  logic                   BTN_START,
    input  logic                   BTN_PAUSE,
    input  logic [Y_W-1:0]         BALL_Y_PIXEL,
    input  logic [BLOCK_COUNT-1:0] BLOCK_STATE,
    output logic                   START_UPDATE,
    output logic                   PHYS_RESET,
    output logic                   BALL_RESET,
    output logic [LIVES_W-1:0]     LIVES,
    output logic [CNT_W-1:0]       BLOCKS_LEFT,
    output logic [2:0]             GAME_STATE
);

    game_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   blocks_q, blocks_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               pause_prev_q, pause_prev_d;
    logic               start_update_q, start_update_d;
    logic               phys_reset_q, phys_reset_d;
    logic               ball_reset_q, ball_reset_d;

    logic               pause_edge_c;
    logic               scan_done_c;
    logic [CNT_W-1:0]   scan_count_c;
    logic               won_c;

    game_sequencer_block_counter u_block_counter (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (FRAME_START),
        .abort   (phys_reset_q),
        .vector  (BLOCK_STATE),
        .done_c  (scan_done_c),
        .count_c (scan_count_c)
    );

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        blocks_d       = blocks_q;
        frame_d        = frame_q;
        pause_prev_d   = BTN_PAUSE;
        start_update_d = 1'b0;
        phys_reset_d   = 1'b0;
        ball_reset_d   = 1'b0;
        pause_edge_c   = BTN_PAUSE && !pause_prev_q;
        won_c          = 1'b0;

        if (scan_done_c) begin
            blocks_d = scan_count_c;
            won_c    = (scan_count_c == '0);
        end

        case (state_q)
            ST_IDLE, ST_OVER, ST_WON: begin
                if (FRAME_START && BTN_START) begin
                    phys_reset_d = 1'b1;
                    lives_d      = LIVES_INIT;
                    blocks_d     = CNT_W'(BLOCK_COUNT);
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                // Clearing the board beats a same-cycle pause; a pause edge beats the frame's update.
                if (won_c) begin
                    state_d = ST_WON;
                end else if (pause_edge_c) begin
                    state_d = ST_PAUSED;
                end else if (FRAME_START) begin
                    if (BALL_Y_PIXEL >= LOST_Y_PIXEL) begin
                        lives_d = lives_q - LIVES_W'(1);
                        frame_d = '0;
                        state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_LOST;
                    end else begin
                        start_update_d = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (pause_edge_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOST: begin
                if (FRAME_START) begin
                    if (frame_q == FRAME_W'(LOST_DELAY_FRAMES - FRAME_W'(1))) begin
                        ball_reset_d = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            lives_q        <= '0;
            blocks_q       <= CNT_W'(BLOCK_COUNT);
            frame_q        <= '0;
            pause_prev_q   <= 1'b0;
            start_update_q <= 1'b0;
            phys_reset_q   <= 1'b0;
            ball_reset_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            blocks_q       <= blocks_d;
            frame_q        <= frame_d;
            pause_prev_q   <= pause_prev_d;
            start_update_q <= start_update_d;
            phys_reset_q   <= phys_reset_d;
            ball_reset_q   <= ball_reset_d;
        end
    end

    assign START_UPDATE = start_update_q;
    assign PHYS_RESET   = phys_reset_q;
    assign BALL_RESET   = ball_reset_q;
    assign LIVES        = lives_q;
    assign BLOCKS_LEFT  = blocks_q;
    assign GAME_STATE   = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a frame-level reference model predicts every cycle's outputs.
module tb_game_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FRAME_START;
    logic        BTN_START;
    logic        BTN_PAUSE;
    logic [9:0]  BALL_Y_PIXEL;
    logic [71:0] BLOCK_STATE;
    logic        START_UPDATE;
    logic        PHYS_RESET;
    logic        BALL_RESET;
    logic [1:0]  LIVES;
    logic [6:0]  BLOCKS_LEFT;
    logic [2:0]  GAME_STATE;

    game_sequencer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .FRAME_START  (FRAME_START),
        .BTN_START    (BTN_START),
        .BTN_PAUSE    (BTN_PAUSE),
        .BALL_Y_PIXEL (BALL_Y_PIXEL),
        .BLOCK_STATE  (BLOCK_STATE),
        .START_UPDATE (START_UPDATE),
        .PHYS_RESET   (PHYS_RESET),
        .BALL_RESET   (BALL_RESET),
        .LIVES        (LIVES),
        .BLOCKS_LEFT  (BLOCKS_LEFT),
        .GAME_STATE   (GAME_STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       su;
        logic       pr;
        logic       br;
        logic [1:0] lives;
        logic [6:0] blocks;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: game rules at frame granularity; a scan is a scheduled latch of a popcount.
    int          m_st;
    int          m_lives;
    int          m_blocks;
    int          m_lost_frames;
    bit          m_prev_pause;
    longint      cyc = 0;
    longint      scan_due = -1;
    int          scan_val;

    bit          cur_rst;
    bit          cur_start;
    bit          cur_pause;
    int          cur_y;
    logic [71:0] cur_blk;

    task automatic model_step(input bit rst, input bit fs);
        bit   pe;
        bit   won;
        obs_t e;
        e = '0;
        if (rst) begin
            m_st = 0; m_lives = 0; m_blocks = 72; m_prev_pause = 0;
            scan_due = -1; m_lost_frames = 0;
        end else begin
            pe = cur_pause && !m_prev_pause;
            m_prev_pause = cur_pause;
            won = 0;
            if (scan_due == cyc) begin
                m_blocks = scan_val;
                won = (scan_val == 0);
                scan_due = -1;
            end
            if (fs) begin
                scan_due = cyc + 72;
                scan_val = $countones(cur_blk);
            end
            case (m_st)
                0, 4, 5: if (fs && cur_start) begin
                    e.pr = 1; m_lives = 3; m_blocks = 72; scan_due = -1; m_st = 1;
                end
                1: begin
                    if (won) m_st = 5;
                    else if (pe) m_st = 2;
                    else if (fs) begin
                        if (cur_y >= 470) begin
                            m_lives = m_lives - 1;
                            m_st = (m_lives == 0) ? 4 : 3;
                            m_lost_frames = 0;
                        end else begin
                            e.su = 1;
                        end
                    end
                end
                2: if (pe) m_st = 1;
                3: if (fs) begin
                    m_lost_frames++;
                    if (m_lost_frames == 30) begin
                        e.br = 1; m_st = 1;
                    end
                end
                default: ;
            endcase
        end
        e.lives  = 2'(m_lives);
        e.blocks = 7'(m_blocks);
        e.st     = 3'(m_st);
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic drive_cycle(input bit fs);
        @(negedge CLK);
        RESET        = cur_rst;
        FRAME_START  = fs;
        BTN_START    = cur_start;
        BTN_PAUSE    = cur_pause;
        BALL_Y_PIXEL = 10'(cur_y);
        BLOCK_STATE  = cur_blk;
        model_step(cur_rst, fs);
        if (cur_rst) begin
            #1;
            vectors++;
            if (GAME_STATE != 3'd0 || LIVES != 2'd0 || BLOCKS_LEFT != 7'd72 ||
                START_UPDATE || PHYS_RESET || BALL_RESET) begin
                miscompares++;
                $display("FAIL rst_immediate: state=%0d lives=%0d blocks=%0d pulses=%b%b%b, required 0/0/72/000",
                         GAME_STATE, LIVES, BLOCKS_LEFT, START_UPDATE, PHYS_RESET, BALL_RESET);
            end
        end
    endtask

    task automatic run_frame(input int gap, input int pause_at);
        for (int i = 0; i < gap; i++) begin
            if (i == pause_at) cur_pause = ~cur_pause;
            drive_cycle(i == 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        cur_rst = 1;
        for (int i = 0; i < cycles; i++) drive_cycle(0);
        cur_rst = 0;
    endtask

    function automatic logic [71:0] bits_set(input int n);
        logic [71:0] v;
        int          k;
        v = '0;
        k = 0;
        while (k < n) begin
            int p;
            p = $urandom_range(0, 71);
            if (!v[p]) begin v[p] = 1'b1; k++; end
        end
        return v;
    endfunction

    // Monitor: compares every registered output cycle against the oldest prediction.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{su: START_UPDATE, pr: PHYS_RESET, br: BALL_RESET, lives: LIVES,
                      blocks: BLOCKS_LEFT, st: GAME_STATE};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got su=%b pr=%b br=%b lives=%0d blocks=%0d state=%0d, expected su=%b pr=%b br=%b lives=%0d blocks=%0d state=%0d",
                             $time, a.su, a.pr, a.br, a.lives, a.blocks, a.st,
                             e.su, e.pr, e.br, e.lives, e.blocks, e.st);
                end
            end
        end
    end

    initial begin
        RESET = 1'b1; FRAME_START = 0; BTN_START = 0; BTN_PAUSE = 0;
        BALL_Y_PIXEL = '0; BLOCK_STATE = '1;
        cur_rst = 0; cur_start = 0; cur_pause = 0; cur_y = 400; cur_blk = '1;
        do_reset(3);

        // New game, then normal frames.
        cur_blk = bits_set(60);
        cur_start = 1; run_frame(80, -1); cur_start = 0;
        for (int f = 0; f < 5; f++) run_frame(80, -1);

        // Lose all three lives; each intermediate loss waits 30 frames for re-serve.
        for (int l = 0; l < 3; l++) begin
            cur_y = 470; run_frame(80, -1); cur_y = 400;
            if (l < 2) for (int f = 0; f < 30; f++) run_frame(76, -1);
        end
        cur_start = 1; run_frame(80, -1); cur_start = 0;

        // Block counting, restart on a short frame, then clear the board.
        cur_blk = bits_set(5); run_frame(80, -1);
        cur_blk = bits_set(17); run_frame(40, -1);
        cur_blk = bits_set(9); run_frame(40, -1);
        run_frame(80, -1);
        cur_blk = '0; run_frame(80, -1);
        run_frame(80, -1);

        // Pause and resume, pause coinciding with a frame, reset while paused.
        cur_blk = bits_set(30);
        cur_start = 1; run_frame(80, -1); cur_start = 0;
        run_frame(80, 20);
        run_frame(80, -1);
        run_frame(80, 30);
        run_frame(80, 10);
        run_frame(80, 0);
        run_frame(80, 35);
        do_reset(2);
        run_frame(80, -1);

        // Randomized play.
        for (int f = 0; f < 250; f++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 2) cur_blk = '0;
            else if (r < 5) cur_blk = bits_set($urandom_range(1, 6));
            else cur_blk = {$urandom(), $urandom(), $urandom()};
            cur_y = ($urandom_range(0, 4) == 0) ? $urandom_range(470, 1023) : $urandom_range(0, 469);
            cur_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
            run_frame($urandom_range(74, 100),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(0, 73) : -1);
        end

        cur_start = 0;
        for (int i = 0; i < 5; i++) drive_cycle(0);
        repeat (5) @(posedge CLK);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game flow controller that sequences the physics engine. It paces physics updates to the display frame rate and issues new-game and re-serve resets. It also tracks lives, pause and win/lose conditions, and keeps a running count of remaining blocks by serially scanning the physics block-state vector. It sits between the VGA timing generator, the button inputs and the physics engine, and its status outputs feed the HUD renderer.

## Interface
- LIVES_INIT, 2'd3: lives granted at new game; legal range 1..3.
- LOST_Y_PIXEL, 10'd470: ball is lost when ball Y (pixels) >= this value.
- LOST_DELAY_FRAMES, 6'd30: frames spent in LOST before re-serve.
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  asynchronous, active-high; clears all state.
- FRAME_START  in  1  one-cycle pulse per frame, at start of vertical blank.
- BTN_START  in  1  debounced level; starts a new game.
- BTN_PAUSE  in  1  debounced level; rising edge toggles pause.
- BALL_Y_PIXEL  in  10  ball Y from physics.
- BLOCK_STATE  in  72  block-present vector from physics.
- START_UPDATE  out  1  one-cycle pulse; physics runs one frame (12 timesteps).
- PHYS_RESET  out  1  one-cycle pulse; full physics reset (new game, all blocks restored).
- BALL_RESET  out  1  one-cycle pulse; physics returns ball to serve-on-paddle, blocks kept.
- LIVES  out  2  remaining lives.
- BLOCKS_LEFT  out  7  latched count of present blocks, 0..72.
- GAME_STATE  out  3  current state encoding.

## Operation
- States: IDLE=0, RUN=1, PAUSED=2, LOST=3, OVER=4, WON=5.
- IDLE/OVER/WON: on FRAME_START with BTN_START=1:
  - pulse PHYS_RESET.
  - LIVES<=LIVES_INIT, BLOCKS_LEFT<=72.
  - abort any scan in progress.
  - go to RUN.
- RUN:
  - On each FRAME_START, pulse START_UPDATE. Exception: the FRAME_START that caused entry to RUN produces no pulse.
  - Same FRAME_START: if BALL_Y_PIXEL >= LOST_Y_PIXEL, LIVES<=LIVES-1. Go to OVER if the new LIVES==0, else go to LOST and clear the frame counter. No START_UPDATE is issued on a loss frame.
- RUN<->PAUSED: toggled on a BTN_PAUSE rising edge in any cycle. The edge detector uses a registered previous value. PAUSED issues no START_UPDATE. Pause edges in other states are ignored.
- LOST:
  - Count FRAME_STARTs.
  - On the LOST_DELAY_FRAMES-th one: pulse BALL_RESET, go to RUN.
  - The serve phase (ball riding paddle until release) is physics-internal and counts as RUN.
- Block scan:
  - Starts on every FRAME_START in every state; index 0..71, one bit per cycle, accumulating a 7-bit count.
  - After index 71, BLOCKS_LEFT<=count.
  - If the count is 0 and the state is RUN, go to WON. In any other state a zero count only updates BLOCKS_LEFT.
  - A FRAME_START during a scan restarts it from index 0; the partial count is discarded.
  - The PHYS_RESET cycle aborts the scan. The next scan starts at the following FRAME_START, so pre-reset state is never latched.
- Simultaneous events:
  - A pause edge and a FRAME_START in the same cycle in RUN: pause wins; no START_UPDATE, no loss check.
  - A BTN_START held through RUN has no effect.
- Only one of PHYS_RESET, BALL_RESET and START_UPDATE is high in any cycle.

## Timing
- Reset values:
  - GAME_STATE=IDLE, LIVES=0, BLOCKS_LEFT=72.
  - START_UPDATE=PHYS_RESET=BALL_RESET=0.
  - Scan idle, pause-edge register=0.
- FRAME_START sampled in cycle t; the resulting START_UPDATE, PHYS_RESET or BALL_RESET is registered and high in cycle t+1 only.
- GAME_STATE and LIVES update in cycle t+1.
- BLOCKS_LEFT valid from cycle t+73 after the FRAME_START at t; the WON transition is also visible at t+73.
- Frame period must exceed 73 cycles; physics needs 48 cycles per frame, so a START_UPDATE pulse is never missed.
- Pause toggle visible one cycle after the rising edge is sampled.
- Asynchronous RESET mid-scan or mid-LOST returns everything to reset values immediately; no pulse is emitted on release.

## Structure
- Shared geometry include gains: state encodings, blockCount=72, default LOST_Y_PIXEL derived from paddle/ball geometry.
- Sub-module block_counter: serial 72-bit scanner.
  - Inputs: CLK, RESET, start, abort, vector.
  - Outputs: done pulse, count[6:0].
- FSM, life counter and frame counter stay in game_sequencer.

## Test plan
- Reset → GAME_STATE=0, LIVES=0, BLOCKS_LEFT=72, all pulses low. BTN_START with FRAME_START → PHYS_RESET high exactly one cycle, LIVES=3, GAME_STATE=1, no START_UPDATE until the next FRAME_START.
- RUN, 5 FRAME_STARTs with BALL_Y_PIXEL=400 → 5 single-cycle START_UPDATEs, each at FRAME_START+1.
- RUN, BALL_Y_PIXEL=470 at FRAME_START → LIVES 3→2, GAME_STATE=3, no START_UPDATE. After 30 more FRAME_STARTs → one BALL_RESET pulse, GAME_STATE=1.
- LIVES=1, ball lost → LIVES=0, GAME_STATE=4, no BALL_RESET. BTN_START → new game, LIVES=3.
- BLOCK_STATE with 5 bits set → BLOCKS_LEFT=5 at FRAME_START+73. BLOCK_STATE=0 in RUN → GAME_STATE=5. FRAME_START pulses 40 cycles apart → no BLOCKS_LEFT update until a full scan completes.
- BTN_PAUSE edge in RUN → GAME_STATE=2, FRAME_STARTs give no START_UPDATE. Second edge → RUN resumes. Assert RESET mid-PAUSED → all reset values.
